// File: rtl/rv32i_package.sv
// Shared rv32i types for the core/cache boundary: request and response channels,
// arbiter FSM states and common constants.
package rv32i_package;

   localparam logic [31:0] RV32I_NOP           = 32'h0000_0013;  // addi x0, x0, 0
   localparam int          ARB_TIMEOUT_DEFAULT = 256;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        rw;     // 1 = write
      logic        valid;
   } cpu_req_type;

   typedef struct packed {
      logic [31:0] data;
      logic        ready;
   } cpu_res_type;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY_IF,
      ARB_BUSY_D,
      ARB_RELEASE
   } arb_state_t;

   // Instruction fetches are always reads, whatever the requester drives on rw.
   function automatic cpu_req_type fetch_req(input cpu_req_type req);
      cpu_req_type r;
      r       = req;
      r.rw    = 1'b0;
      r.valid = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/rv32i_mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of the cache controller, one transaction
// at a time, with a hang watchdog. Define RV32I_ARB_ROUND_ROBIN_EN for round-robin priority.
module rv32i_mem_arbiter
   import rv32i_package::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
   parameter int CNT_W          = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  cpu_req_type if_req,
   output cpu_res_type if_res,
   input  cpu_req_type d_req,
   output cpu_res_type d_res,
   output cpu_req_type mem_req,
   input  cpu_res_type mem_res,
   output logic        grant_d,
   output logic        timeout_err
);

   localparam bit               WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

   arb_state_t       state_q, state_d;
   cpu_req_type      mem_req_q, mem_req_d;
   logic             grant_d_q, grant_d_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy;
   logic             expire;
   logic             pick_d;

   assign busy   = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_D);
   // A real response in the expiry cycle takes precedence over the watchdog.
   assign expire = WD_EN && busy && !mem_res.ready && (cnt_q == WD_LAST);

`ifdef RV32I_ARB_ROUND_ROBIN_EN
   // On contention the port that did not win last time goes first.
   assign pick_d = d_req.valid && (!if_req.valid || !grant_d_q);
`else
   assign pick_d = d_req.valid;
`endif

   assign mem_req = mem_req_q;
   assign grant_d = grant_d_q;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      grant_d_d   = grant_d_q;
      cnt_d       = cnt_q;
      if_res      = '0;
      d_res       = '0;
      timeout_err = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (pick_d) begin
               state_d         = ARB_BUSY_D;
               mem_req_d       = d_req;
               mem_req_d.valid = 1'b1;
               grant_d_d       = 1'b1;
               cnt_d           = '0;
            end else if (if_req.valid) begin
               state_d   = ARB_BUSY_IF;
               mem_req_d = fetch_req(if_req);
               grant_d_d = 1'b0;
               cnt_d     = '0;
            end
         end

         ARB_BUSY_IF, ARB_BUSY_D: begin
            if (state_q == ARB_BUSY_IF) begin
               if_res.ready = mem_res.ready || expire;
               if_res.data  = expire ? RV32I_NOP : mem_res.data;
            end else begin
               d_res.ready = mem_res.ready || expire;
               d_res.data  = expire ? 32'h0 : mem_res.data;
            end
            timeout_err = expire;
            if (mem_res.ready || expire) begin
               mem_req_d.valid = 1'b0;
               state_d         = ARB_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Guarantees the cache controller one cycle of valid low between grants.
         ARB_RELEASE: state_d = ARB_IDLE;

         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values.
      if (rst) begin
         state_q   <= ARB_IDLE;
         mem_req_q <= '0;
         grant_d_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= mem_req_d;
         grant_d_q <= grant_d_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter (watchdog shortened to 4 cycles); expectations
// follow RV32I_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_rv32i_mem_arbiter;
   import rv32i_package::*;

`ifdef RV32I_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   cpu_req_type if_req, d_req, mem_req;
   cpu_res_type if_res, d_res, mem_res;
   logic        grant_d, timeout_err;

   int n_checks = 0;
   int n_errors = 0;
   bit last_d   = 1'b0;   // bench model of the last winner

   rv32i_mem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .if_res      (if_res),
      .d_req       (d_req),
      .d_res       (d_res),
      .mem_req     (mem_req),
      .mem_res     (mem_res),
      .grant_d     (grant_d),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic cpu_req_type mk_req(input logic [31:0] a, input logic [31:0] d,
                                          input logic rw);
      cpu_req_type r;
      r.addr  = a;
      r.data  = d;
      r.rw    = rw;
      r.valid = 1'b1;
      return r;
   endfunction

   // Entered in an IDLE cycle with requests already driven; returns in the next IDLE cycle.
   task automatic txn(input string tag, input bit exp_d, input cpu_req_type exp_req,
                      input logic [31:0] rdata, input int lat);
      check({tag, "_pre_valid"}, mem_req.valid, 1'b0);
      step();
      check({tag, "_mem_req"}, mem_req, exp_req);
      check({tag, "_grant_d"}, grant_d, exp_d);
      for (int i = 1; i < lat; i++) begin
         check({tag, "_wait_ready"}, {if_res.ready, d_res.ready}, 2'b00);
         step();
      end
      mem_res = '{data: rdata, ready: 1'b1};
      #1;
      if (exp_d) begin
         check({tag, "_d_res"}, d_res, {rdata, 1'b1});
         check({tag, "_if_res_idle"}, if_res, 33'h0);
      end else begin
         check({tag, "_if_res"}, if_res, {rdata, 1'b1});
         check({tag, "_d_res_idle"}, d_res, 33'h0);
      end
      check({tag, "_no_timeout"}, timeout_err, 1'b0);
      last_d = exp_d;
      step();
      mem_res = '0;
      if (exp_d) d_req.valid = 1'b0;
      else       if_req.valid = 1'b0;
      #1;
      check({tag, "_release_valid"}, mem_req.valid, 1'b0);
      check({tag, "_release_ready"}, {if_res.ready, d_res.ready}, 2'b00);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      cpu_req_type dreq, ireq;
      bit          first_d, exp_d;
      int          if_grants;
      int          d_idx;

      rst     = 1'b1;
      if_req  = '0;
      d_req   = '0;
      mem_res = '0;
      step();
      step();
      check("rst_mem_req", mem_req, 66'h0);
      check("rst_if_res", if_res, 33'h0);
      check("rst_d_res", d_res, 33'h0);
      check("rst_flags", {grant_d, timeout_err}, 2'b00);
      rst = 1'b0;

      // Single fetch; rw driven high by the requester must be forced to read.
      if_req = mk_req(32'h0000_0100, 32'h0000_AAAA, 1'b1);
      txn("if_single", 1'b0, mk_req(32'h0000_0100, 32'h0000_AAAA, 1'b0), 32'hDEAD_BEEF, 3);

      d_req = mk_req(32'h0000_1000, 32'h0000_0077, 1'b1);
      txn("d_single", 1'b1, d_req, 32'h0000_1111, 1);

      // Simultaneous requests; the last grant was D.
      dreq    = mk_req(32'h0000_2000, 32'h0000_0055, 1'b1);
      ireq    = mk_req(32'h0000_0300, 32'h0000_0000, 1'b0);
      d_req   = dreq;
      if_req  = ireq;
      first_d = RR ? !last_d : 1'b1;
      txn("both_first", first_d, first_d ? dreq : ireq, 32'h0000_00F1, 2);
      txn("both_second", !first_d, first_d ? ireq : dreq, 32'h0000_00F2, 2);

      // Ten grants with IF held valid and D always presenting a new request.
      if_grants = 0;
      d_idx     = 0;
      ireq      = mk_req(32'h0000_0400, 32'h0, 1'b0);
      if_req    = ireq;
      d_req     = mk_req(32'h0000_3000, 32'h0000_0100, 1'b0);
      for (int g = 0; g < 10; g++) begin
         exp_d = RR ? !last_d : 1'b1;
         txn("stream", exp_d, exp_d ? d_req : ireq, 32'h1000_0000 + g, 1);
         if (exp_d) begin
            d_idx++;
            d_req = mk_req(32'h0000_3000 + 32'(d_idx * 4), 32'h0000_0100 + 32'(d_idx), d_idx[0]);
         end else begin
            if_grants++;
            if_req = ireq;
         end
      end
      check("stream_if_grants", if_grants, RR ? 5 : 0);
      if_req.valid = 1'b0;
      d_req.valid  = 1'b0;
      step();

      // Watchdog expiry on a fetch, then a late downstream ready.
      if_req = mk_req(32'h0000_0500, 32'h0, 1'b0);
      check("wd_pre_valid", mem_req.valid, 1'b0);
      step();
      check("wd_mem_req", mem_req, mk_req(32'h0000_0500, 32'h0, 1'b0));
      for (int i = 1; i < 4; i++) begin
         check("wd_wait", {if_res.ready, timeout_err}, 2'b00);
         step();
      end
      check("wd_if_res", if_res, {RV32I_NOP, 1'b1});
      check("wd_pulse", timeout_err, 1'b1);
      check("wd_d_res", d_res, 33'h0);
      step();
      if_req.valid = 1'b0;
      #1;
      check("wd_release", {mem_req.valid, timeout_err, if_res.ready}, 3'b000);
      step();
      mem_res = '{data: 32'h0000_0BAD, ready: 1'b1};
      #1;
      check("late_if_res", if_res, 33'h0);
      check("late_d_res", d_res, 33'h0);
      check("late_timeout", timeout_err, 1'b0);
      step();
      mem_res = '0;
      #1;
      check("late_no_grant", mem_req.valid, 1'b0);
      step();

      // Real response in the expiry cycle wins.
      if_req = mk_req(32'h0000_0600, 32'h0, 1'b0);
      txn("coincide", 1'b0, if_req, 32'hCAFE_F00D, 4);

      // Reset in the middle of a data transaction.
      d_req = mk_req(32'h0000_0700, 32'h0000_0009, 1'b0);
      check("mid_rst_pre", mem_req.valid, 1'b0);
      step();
      check("mid_rst_busy", {mem_req.valid, grant_d}, 2'b11);
      rst = 1'b1;
      step();
      rst         = 1'b0;
      d_req.valid = 1'b0;
      last_d      = 1'b0;
      #1;
      check("mid_rst_mem_req", mem_req, 66'h0);
      check("mid_rst_d_res", d_res, 33'h0);
      check("mid_rst_grant", grant_d, 1'b0);
      if_req = mk_req(32'h0000_0800, 32'h0, 1'b0);
      txn("post_rst", 1'b0, if_req, 32'h1234_5678, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
